// File: rtl/matrix_input_parser.sv
// matrix_input_parser: turns an ASCII decimal stream "rows cols e0 .. eN-1"
// from the UART receiver into row-major writes into matrix storage.
// Reports the committed dimensions, a done pulse, or an err pulse with a code.
module matrix_input_parser #(
  parameter int MAX_DIM        = 5,
  parameter int MAX_VAL        = 9,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [2:0] mat_row,
  output logic [2:0] mat_col,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [12:0]   DIM_LIM = 13'(MAX_DIM);
  localparam logic [12:0]   VAL_LIM = 13'(MAX_VAL);

  localparam logic [1:0] E_CHAR = 2'b00;
  localparam logic [1:0] E_DIM  = 2'b01;
  localparam logic [1:0] E_VAL  = 2'b10;
  localparam logic [1:0] E_TIME = 2'b11;

  // Errors go straight back to IDLE; the err pulse itself marks the abort.
  typedef enum logic [1:0] {IDLE, GET_ROW, GET_COL, GET_ELEM} state_t;

  state_t        state;
  logic [8:0]    acc;
  logic          in_num;
  logic [4:0]    elem_cnt;
  logic [TW-1:0] tcnt;

  logic          is_digit, is_sep;
  logic [3:0]    digit;
  logic [12:0]   acc_next;
  logic [5:0]    total;
  logic          last_elem;
  logic          abort;
  logic [1:0]    abort_code;

  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep    = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign digit     = 4'(rx_data - 8'h30);
  // Wide enough that acc*10+9 never wraps before the range check sees it.
  assign acc_next  = 13'(acc) * 13'd10 + 13'(digit);
  assign total     = 6'(mat_row) * 6'(mat_col);
  assign last_elem = (6'(elem_cnt) == total - 6'd1);

  // Decide whether this cycle aborts the parse, and with which code.
  // An accepted byte always takes priority over timeout expiry.
  always_comb begin
    abort      = 1'b0;
    abort_code = E_CHAR;
    if (state != IDLE) begin
      if (rx_valid) begin
        if (is_digit) begin
          if (state == GET_ELEM) begin
            if (acc_next > VAL_LIM) begin
              abort      = 1'b1;
              abort_code = E_VAL;
            end
          end else if (acc_next > DIM_LIM) begin
            abort      = 1'b1;
            abort_code = E_DIM;
          end
        end else if (!is_sep) begin
          abort      = 1'b1;
          abort_code = E_CHAR;
        end else if (in_num && state != GET_ELEM && acc == 9'd0) begin
          abort      = 1'b1;
          abort_code = E_DIM;
        end
      end else if (tcnt == TLAST) begin
        abort      = 1'b1;
        abort_code = E_TIME;
      end
    end
  end

  // Parser FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      in_num   <= 1'b0;
      elem_cnt <= '0;
      tcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      mat_row  <= '0;
      mat_col  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;
      if (state == IDLE) begin
        // A byte arriving with start is dropped: the arm wins.
        if (start) begin
          busy     <= 1'b1;
          acc      <= '0;
          in_num   <= 1'b0;
          elem_cnt <= '0;
          tcnt     <= '0;
          mat_row  <= '0;
          mat_col  <= '0;
          err_code <= E_CHAR;
          state    <= GET_ROW;
        end
      end else if (abort) begin
        err      <= 1'b1;
        err_code <= abort_code;
        busy     <= 1'b0;
        acc      <= '0;
        in_num   <= 1'b0;
        state    <= IDLE;
      end else if (rx_valid) begin
        tcnt <= '0;
        if (is_digit) begin
          acc    <= acc_next[8:0];
          in_num <= 1'b1;
        end else if (in_num) begin
          // Separator closing a number; bare separators fall through idle.
          acc    <= '0;
          in_num <= 1'b0;
          case (state)
            GET_ROW: begin
              mat_row <= acc[2:0];
              state   <= GET_COL;
            end
            GET_COL: begin
              mat_col <= acc[2:0];
              state   <= GET_ELEM;
            end
            default: begin
              wr_en    <= 1'b1;
              wr_addr  <= elem_cnt;
              wr_data  <= acc[7:0];
              elem_cnt <= elem_cnt + 5'd1;
              if (last_elem) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          endcase
        end
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Directed bench for matrix_input_parser (TIMEOUT_CYCLES shortened to 50).
module tb_matrix_input_parser;

  logic       clk = 1'b0;
  logic       rst_n, start, rx_valid;
  logic [7:0] rx_data;
  logic       busy, done, err, wr_en;
  logic [1:0] err_code;
  logic [2:0] mat_row, mat_col;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int compared = 0;
  int mismatched = 0;

  matrix_input_parser #(.MAX_DIM(5), .MAX_VAL(9), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .mat_row(mat_row), .mat_col(mat_col),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Event log of pulses, sampled mid-cycle; the initial block only reads it.
  int waddr_q[$];
  int wdata_q[$];
  int ndone = 0;
  int nerr = 0;
  int done_addr = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        waddr_q.push_back(int'(wr_addr));
        wdata_q.push_back(int'(wr_data));
      end
      if (done) begin
        ndone <= ndone + 1;
        done_addr <= int'(wr_addr);
      end
      if (err) nerr <= nerr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic arm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, err, err_code, mat_row, mat_col, wr_en, wr_addr, wr_data});
  endfunction

  initial begin
    int wb, db, eb;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x3 matrix with CR-free newlines
    wb = waddr_q.size(); db = ndone; eb = nerr;
    arm();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    send_str("2 3\n1 2 3\n4 5 6\n");
    chk("t1_done_pulse", 32'(done), 32'd1);
    chk("t1_busy_clear", 32'(busy), 32'd0);
    settle();
    chk("t1_mat_row", 32'(mat_row), 32'd2);
    chk("t1_mat_col", 32'(mat_col), 32'd3);
    chk("t1_nwrites", 32'(waddr_q.size() - wb), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (wb + i < waddr_q.size()) begin
        chk($sformatf("t1_addr%0d", i), 32'(waddr_q[wb + i]), 32'(i));
        chk($sformatf("t1_data%0d", i), 32'(wdata_q[wb + i]), 32'(i + 1));
      end
    end
    chk("t1_ndone", 32'(ndone - db), 32'd1);
    chk("t1_done_addr", 32'(done_addr), 32'd5);
    chk("t1_no_err", 32'(nerr - eb), 32'd0);
    send_str("7 ");
    settle();
    chk("t1_ignored_after_done", 32'(waddr_q.size() - wb), 32'd6);

    // 1x1 with separator runs and CRLF
    wb = waddr_q.size(); db = ndone;
    arm();
    send_str("  1\r\n1 \r\n7\n");
    settle();
    chk("t2_mat_row", 32'(mat_row), 32'd1);
    chk("t2_mat_col", 32'(mat_col), 32'd1);
    chk("t2_nwrites", 32'(waddr_q.size() - wb), 32'd1);
    if (waddr_q.size() > wb) begin
      chk("t2_addr", 32'(waddr_q[wb]), 32'd0);
      chk("t2_data", 32'(wdata_q[wb]), 32'd7);
    end
    chk("t2_ndone", 32'(ndone - db), 32'd1);

    // Row count out of range on the '6' digit
    wb = waddr_q.size(); db = ndone;
    arm();
    send("6");
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_err_code", 32'(err_code), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    send_str(" 2 ");
    settle();
    chk("t3_no_writes", 32'(waddr_q.size() - wb), 32'd0);
    chk("t3_code_held", 32'(err_code), 32'd1);
    arm();
    chk("t3_code_cleared", 32'(err_code), 32'd0);
    send_str("2 2 1 2 3 4 ");
    settle();
    chk("t3_recover_writes", 32'(waddr_q.size() - wb), 32'd4);
    chk("t3_recover_done", 32'(ndone - db), 32'd1);
    chk("t3_recover_row", 32'(mat_row), 32'd2);

    // Element overflow on the second digit of "12"
    wb = waddr_q.size();
    arm();
    send_str("1 1 1");
    send("2");
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_code", 32'(err_code), 32'd2);
    settle();
    chk("t4_no_writes", 32'(waddr_q.size() - wb), 32'd0);

    // Bad character after one element has been written
    wb = waddr_q.size();
    arm();
    send_str("2 2 1 ");
    send("x");
    chk("t4b_err", 32'(err), 32'd1);
    chk("t4b_err_code", 32'(err_code), 32'd0);
    settle();
    chk("t4b_nwrites", 32'(waddr_q.size() - wb), 32'd1);
    if (waddr_q.size() > wb) begin
      chk("t4b_addr", 32'(waddr_q[wb]), 32'd0);
      chk("t4b_data", 32'(wdata_q[wb]), 32'd1);
    end
    chk("t4b_rows_kept", 32'(mat_row), 32'd2);

    // Timeout 50 cycles after the last strobe
    arm();
    send_str("1 ");
    repeat (49) @(posedge clk);
    #1;
    chk("t5_no_err_at_49", 32'(err), 32'd0);
    chk("t5_busy_at_49", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t5_err_at_50", 32'(err), 32'd1);
    chk("t5_err_code", 32'(err_code), 32'd3);
    chk("t5_busy_clear", 32'(busy), 32'd0);

    // A byte landing on cycle 50 beats the timeout
    wb = waddr_q.size(); db = ndone;
    arm();
    send_str("1 ");
    repeat (49) @(posedge clk);
    #1;
    send("1");
    chk("t5b_no_err", 32'(err), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd1);
    send_str(" 5 ");
    settle();
    chk("t5b_done", 32'(ndone - db), 32'd1);
    if (wdata_q.size() > wb) chk("t5b_data", 32'(wdata_q[wb]), 32'd5);

    // start and rx_valid together in IDLE: byte dropped, arm taken
    wb = waddr_q.size(); eb = nerr;
    start = 1'b1; rx_valid = 1'b1; rx_data = "x";
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    chk("t6_armed", 32'(busy), 32'd1);
    send_str("1 1 4 ");
    settle();
    chk("t6_no_err", 32'(nerr - eb), 32'd0);
    chk("t6_nwrites", 32'(waddr_q.size() - wb), 32'd1);
    if (wdata_q.size() > wb) chk("t6_data", 32'(wdata_q[wb]), 32'd4);

    // Reset mid-stream, then a clean parse
    arm();
    send_str("2 2 3 ");
    chk("t7_wr_before_reset", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb = waddr_q.size(); db = ndone;
    arm();
    send_str("2 2 3 4 5 6 ");
    settle();
    chk("t7_nwrites", 32'(waddr_q.size() - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wb + i < waddr_q.size()) begin
        chk($sformatf("t7_addr%0d", i), 32'(waddr_q[wb + i]), 32'(i));
        chk($sformatf("t7_data%0d", i), 32'(wdata_q[wb + i]), 32'(i + 3));
      end
    end
    chk("t7_done", 32'(ndone - db), 32'd1);
    chk("t7_done_addr", 32'(done_addr), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
